input_conditioner: RTL and testbench

Front-end conditioning stage sitting directly upstream of the Nios II SoC's key and switch PIO inputs on the MAX10 board. Raw asynchronous KEY and SW pins pass through a two-flop synchronizer and a per-bit counter-based debouncer. The block presents clean levels plus single-cycle key press/release and switch-change pulses to the SoC PIO exports and other fabric logic. Keys are active-low (idle high); switches are active-high.

---
 rtl/input_conditioner.sv | 80 ++++++++
 tb/tb_input_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Two-flop synchronizer plus per-bit counter debouncer for the KEY and SW pins.
// Emits clean levels and single-cycle key press/release and switch-change pulses.
module input_conditioner #(
    parameter int N_KEY           = 2,
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_KEY-1:0] key_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_KEY-1:0] key_db,
    output logic [N_SW-1:0]  sw_db,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic             sw_change
);

    // Keys and switches share one bit vector: keys in the upper bits, switches below.
    localparam int N_ALL = N_KEY + N_SW;
    localparam logic [N_ALL-1:0] RST_VAL  = {{N_KEY{1'b1}}, {N_SW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_ALL-1:0]            s1_q, s1_d;
    logic [N_ALL-1:0]            s2_q, s2_d;
    logic [N_ALL-1:0]            db_q, db_d;
    logic [N_ALL-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_KEY-1:0]            key_press_q, key_press_d;
    logic [N_KEY-1:0]            key_release_q, key_release_d;
    logic                        sw_change_q, sw_change_d;

    always_comb begin
        s1_d  = {key_raw, sw_raw};
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        // Any cycle where the synchronized input matches the accepted level restarts the count.
        for (int i = 0; i < N_ALL; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        key_press_d   =  db_q[N_ALL-1:N_SW] & ~db_d[N_ALL-1:N_SW];
        key_release_d = ~db_q[N_ALL-1:N_SW] &  db_d[N_ALL-1:N_SW];
        sw_change_d   = |(db_q[N_SW-1:0] ^ db_d[N_SW-1:0]);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_q          <= RST_VAL;
            s2_q          <= RST_VAL;
            db_q          <= RST_VAL;
            cnt_q         <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            sw_change_q   <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            db_q          <= db_d;
            cnt_q         <= cnt_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            sw_change_q   <= sw_change_d;
        end
    end

    assign key_db      = db_q[N_ALL-1:N_SW];
    assign sw_db       = db_q[N_SW-1:0];
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign sw_change   = sw_change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus
// random stimulus compared every cycle against a sliding-window reference model.
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int NK = 2;
    localparam int NS = 8;
    localparam int NT = NK + NS;
    localparam logic [NT-1:0] RV = {2'b11, 8'h00};

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_raw;
    logic [NS-1:0] sw_raw;
    logic [NK-1:0] key_db;
    logic [NS-1:0] sw_db;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          sw_change;

    int checks   = 0;
    int failures = 0;

    input_conditioner #(
        .N_KEY(NK), .N_SW(NS), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .key_raw(key_raw),
        .sw_raw(sw_raw),
        .key_db(key_db),
        .sw_db(sw_db),
        .key_press(key_press),
        .key_release(key_release),
        .sw_change(sw_change)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A bit is accepted once its synchronized value has disagreed with the accepted
    // level on each of the last D edges, all of them after that bit's previous acceptance.
    logic [NT-1:0] m_s1 = RV, m_s2 = RV, m_db = RV, m_nd;
    logic [NK-1:0] m_kp = '0, m_kr = '0;
    logic          m_sc = 1'b0;
    logic [NT-1:0] mis_hist[$];
    int            last_acc[NT];
    int            edge_no = 0;
    bit            all_mis;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = RV; m_s2 = RV; m_db = RV;
                m_kp = '0; m_kr = '0; m_sc = 1'b0;
                mis_hist.delete();
                edge_no = 0;
                for (int b = 0; b < NT; b++) last_acc[b] = 0;
            end else begin
                edge_no++;
                mis_hist.push_back(m_s2 ^ m_db);
                if (mis_hist.size() > D) void'(mis_hist.pop_front());
                m_nd = m_db;
                for (int b = 0; b < NT; b++) begin
                    if (edge_no - last_acc[b] >= D) begin
                        all_mis = 1'b1;
                        for (int j = 0; j < mis_hist.size(); j++)
                            if (!mis_hist[j][b]) all_mis = 1'b0;
                        if (all_mis) begin
                            m_nd[b]     = m_s2[b];
                            last_acc[b] = edge_no;
                        end
                    end
                end
                m_kp = m_db[NT-1:NS] & ~m_nd[NT-1:NS];
                m_kr = ~m_db[NT-1:NS] & m_nd[NT-1:NS];
                m_sc = (m_db[NS-1:0] != m_nd[NS-1:0]);
                m_db = m_nd;
                m_s2 = m_s1;
                m_s1 = {key_raw, sw_raw};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("model_key_db",      8'(key_db),      8'(m_db[NT-1:NS]));
            chk("model_sw_db",       sw_db,           m_db[NS-1:0]);
            chk("model_key_press",   8'(key_press),   8'(m_kp));
            chk("model_key_release", 8'(key_release), 8'(m_kr));
            chk("model_sw_change",   8'(sw_change),   8'(m_sc));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pulses;
    int idx;
    int r;

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b1;
        key_raw = 2'b00;
        sw_raw  = 8'hFF;
        #1 rst_n = 1'b0;

        // Reset holds reset values regardless of raw inputs
        edges(3);
        chk("reset_key_db",      8'(key_db), 8'h03);
        chk("reset_sw_db",       sw_db,      8'h00);
        chk("reset_key_press",   8'(key_press),   8'h00);
        chk("reset_key_release", 8'(key_release), 8'h00);
        chk("reset_sw_change",   8'(sw_change),   8'h00);
        #1 key_raw = 2'b11; sw_raw = 8'h00;
        edges(1);
        #1 rst_n = 1'b1;
        edges(4);

        // Clean press then release of key 0
        #1 key_raw = 2'b10;
        edges(5);
        chk("press_e5_key_db", 8'(key_db), 8'h03);
        edges(1);
        chk("press_e6_key_db",    8'(key_db),      8'h02);
        chk("press_e6_key_press", 8'(key_press),   8'h01);
        chk("press_e6_release",   8'(key_release), 8'h00);
        edges(1);
        chk("press_e7_key_press", 8'(key_press), 8'h00);
        #1 key_raw = 2'b11;
        edges(5);
        chk("rel_e5_key_db", 8'(key_db), 8'h02);
        edges(1);
        chk("rel_e6_key_db",      8'(key_db),      8'h03);
        chk("rel_e6_key_release", 8'(key_release), 8'h01);
        edges(1);
        chk("rel_e7_key_release", 8'(key_release), 8'h00);

        // Bouncing key 1: 0,1,0,1 then 0 held (final 0 first sampled on edge 5)
        #1 key_raw = 2'b01; edges(1);
        #1 key_raw = 2'b11; edges(1);
        #1 key_raw = 2'b01; edges(1);
        #1 key_raw = 2'b11; edges(1);
        #1 key_raw = 2'b01;
        pulses = 0;
        for (int i = 5; i <= 12; i++) begin
            edges(1);
            if (key_press[1]) pulses++;
            if (i == 9)  chk("bounce_e9_key_db",  8'(key_db), 8'h03);
            if (i == 10) chk("bounce_e10_key_db", 8'(key_db), 8'h01);
        end
        chk("bounce_press_count", 8'(pulses), 8'd1);
        #1 key_raw = 2'b11;
        edges(8);

        // Switch 3 glitch of three cycles never accepted
        #1 sw_raw = 8'h08;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            edges(1);
            if (sw_change) pulses++;
        end
        #1 sw_raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            if (sw_change) pulses++;
        end
        chk("glitch_sw_db",      sw_db,       8'h00);
        chk("glitch_sw_changes", 8'(pulses),  8'd0);

        // Several switches change on one edge: one pulse
        #1 sw_raw = 8'hA5;
        edges(5);
        chk("multi_e5_sw_db", sw_db, 8'h00);
        edges(1);
        chk("multi_e6_sw_db",     sw_db,          8'hA5);
        chk("multi_e6_sw_change", 8'(sw_change),  8'h01);
        edges(1);
        chk("multi_e7_sw_change", 8'(sw_change),  8'h00);

        // Reset mid-count discards pending press of key 0
        #1 key_raw = 2'b10;
        edges(3);
        #1 rst_n = 1'b0;
        edges(1);
        #1 rst_n = 1'b1;
        #1 chk("rstmid_key_db_now", 8'(key_db), 8'h03);
        edges(5);
        chk("rstmid_e5_key_db", 8'(key_db), 8'h03);
        edges(1);
        chk("rstmid_e6_key_db",    8'(key_db),    8'h02);
        chk("rstmid_e6_key_press", 8'(key_press), 8'h01);
        #1 key_raw = 2'b11;
        edges(8);

        // Random stimulus with occasional single-cycle resets
        for (int n = 0; n < 4000; n++) begin
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 12) begin
                    idx = $urandom_range(0, NK - 1);
                    key_raw[idx] = ~key_raw[idx];
                end else if (r < 24) begin
                    idx = $urandom_range(0, NS - 1);
                    sw_raw[idx] = ~sw_raw[idx];
                end else if (r < 27) begin
                    sw_raw = 8'($urandom);
                end else if (r == 99 && $urandom_range(0, 3) == 0) begin
                    rst_n = 1'b0;
                end
            end
            edges(1);
        end
        #1 rst_n = 1'b1;
        edges(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
